// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the master drives the controls,
// and the slave (the timer) returns the count and its status flags.
interface countdown_timer_if #(
   parameter int WIDTH = 8
);
   logic             Enable;
   logic             Load;
   logic [WIDTH-1:0] LoadValue;
   logic             Start;
   logic             Stop;
   logic             AutoReload;
   logic [WIDTH-1:0] CounterValue;
   logic             Busy;
   logic             Done;

   modport master (
      output Enable, Load, LoadValue, Start, Stop, AutoReload,
      input  CounterValue, Busy, Done
   );

   modport slave (
      input  Enable, Load, LoadValue, Start, Stop, AutoReload,
      output CounterValue, Busy, Done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot and periodic modes and a three-state Moore FSM.
// Define COUNTDOWN_PRESCALE_EN to add an Enable prescaler of PRESCALE cycles per tick.
module countdown_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic               Clock,
   input  logic               Clear_b,
   countdown_timer_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tick;

   if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
      $error("countdown_timer: PRESCALE must be in 2..255");
   end

`ifdef COUNTDOWN_PRESCALE_EN
   localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

   logic [7:0] pre_q, pre_d;

   assign tick = bus.Enable && (state_q == RUN) && (pre_q == PRE_LAST);

   // The prescaler restarts whenever a countdown is (re)armed or left.
   always_comb begin
      pre_d = pre_q;
      if (bus.Load || bus.Stop || state_q != RUN) begin
         pre_d = '0;
      end else if (bus.Enable) begin
         pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 8'd1;
      end
   end

   always_ff @(posedge Clock or negedge Clear_b) begin
      if (!Clear_b) pre_q <= '0;
      else          pre_q <= pre_d;
   end
`else
   assign tick = bus.Enable;
`endif

   // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      if (bus.Load) begin
         reload_d = bus.LoadValue;
         count_d  = bus.LoadValue;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.Start) state_d = (count_q != '0) ? RUN : DONE;
            end
            RUN: begin
               if (bus.Stop) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     count_d = '0;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (bus.AutoReload && reload_q != '0) begin
                  state_d = RUN;
                  count_d = reload_q;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge Clock or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign bus.CounterValue = count_q;
   assign bus.Busy         = (state_q == RUN);
   assign bus.Done         = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer with hand-computed expectations
// and hand-written sequences for asynchronous reset and the optional prescaler.
module tb_countdown_timer;

   logic Clock;
   logic Clear_b;
   int   checks;
   int   errors;

   countdown_timer_if #(.WIDTH(8)) bus ();

   countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut (
      .Clock   (Clock),
      .Clear_b (Clear_b),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic       load;
      logic [7:0] lv;
      logic       start;
      logic       stop;
      logic       en;
      logic       ar;
      logic [7:0] cnt;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int cnt, input int busy, input int done);
      check({tag, " CounterValue"}, int'(bus.CounterValue), cnt);
      check({tag, " Busy"},         int'(bus.Busy),         busy);
      check({tag, " Done"},         int'(bus.Done),         done);
   endtask

   task automatic drive(input logic load, input logic [7:0] lv, input logic start,
                        input logic stop, input logic en, input logic ar);
      bus.Load       = load;
      bus.LoadValue  = lv;
      bus.Start      = start;
      bus.Stop       = stop;
      bus.Enable     = en;
      bus.AutoReload = ar;
   endtask

   // Drive away from the active edge, then sample 1 time unit after it.
   task automatic step(input logic load, input logic [7:0] lv, input logic start,
                       input logic stop, input logic en, input logic ar);
      @(negedge Clock);
      drive(load, lv, start, stop, en, ar);
      @(posedge Clock);
      #1;
   endtask

   function automatic vec_t mk(logic load, logic [7:0] lv, logic start, logic stop,
                               logic en, logic ar, logic [7:0] cnt, logic busy, logic done);
      vec_t v;
      v.load = load; v.lv = lv; v.start = start; v.stop = stop;
      v.en = en; v.ar = ar; v.cnt = cnt; v.busy = busy; v.done = done;
      return v;
   endfunction

   initial begin
      checks  = 0;
      errors  = 0;
      Clear_b = 1'b0;
      drive(0, 8'd0, 0, 0, 0, 0);
      #12;
      check_outs("reset", 0, 0, 0);
      @(negedge Clock);
      Clear_b = 1'b1;

`ifndef COUNTDOWN_PRESCALE_EN
      //         load lv    start stop en ar   cnt  busy done
      // one-shot countdown from 3
      vecs.push_back(mk(1, 8'd3, 0, 0, 0, 0, 8'd3, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd3, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0));
      // periodic mode, reload 2: Done every 3 cycles
      vecs.push_back(mk(1, 8'd2, 0, 0, 0, 1, 8'd2, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd2, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd2, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0));
      // stop and resume from the held value
      vecs.push_back(mk(1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd5, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd4, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd3, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 1, 1, 0, 8'd3, 0, 0));
      vecs.push_back(mk(0, 8'd0, 0, 1, 1, 0, 8'd3, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd3, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd2, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd0, 0, 0));
      // zero load: immediate Done, no reload even in periodic mode
      vecs.push_back(mk(1, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 0, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd0, 0, 0));
      // Load beats Start in IDLE, and Load aborts RUN
      vecs.push_back(mk(1, 8'd4, 1, 0, 1, 0, 8'd4, 0, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd4, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd4, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd3, 1, 0));
      vecs.push_back(mk(1, 8'd7, 0, 1, 1, 0, 8'd7, 0, 0));
      // Stop ignored in DONE; periodic reload of 1
      vecs.push_back(mk(1, 8'd1, 0, 0, 0, 1, 8'd1, 0, 0));
      vecs.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd0, 0, 1));
      vecs.push_back(mk(0, 8'd0, 0, 1, 1, 1, 8'd1, 1, 0));
      vecs.push_back(mk(0, 8'd0, 0, 1, 1, 1, 8'd1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].ar);
         check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].busy, vecs[i].done);
      end

      // Asynchronous reset between edges aborts RUN with no Done pulse
      step(1, 8'd6, 0, 0, 0, 1);
      step(0, 8'd0, 1, 0, 1, 1);
      step(0, 8'd0, 0, 0, 1, 1);
      check_outs("pre-reset", 5, 1, 0);
      @(negedge Clock);
      Clear_b = 1'b0;
      #1;
      check_outs("async reset", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         check_outs($sformatf("held reset%0d", i), 0, 0, 0);
      end
      @(negedge Clock);
      Clear_b = 1'b1;
      drive(0, 8'd0, 1, 0, 1, 1);
      @(posedge Clock);
      #1;
      check_outs("first edge after reset", 0, 0, 1);
      step(0, 8'd0, 0, 0, 1, 1);
      check_outs("reload cleared by reset", 0, 0, 0);
`else
      // Prescaled: decrements on the 4th and 8th RUN cycles, Done after the 8th
      step(1, 8'd2, 0, 0, 0, 0);
      check_outs("pre load", 2, 0, 0);
      step(0, 8'd0, 1, 0, 1, 0);
      check_outs("pre start", 2, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 8'd0, 0, 0, 1, 0);
         check_outs($sformatf("pre run%0d", i), (i < 4) ? 2 : (i < 8) ? 1 : 0,
                    (i < 8) ? 1 : 0, (i == 8) ? 1 : 0);
      end
      step(0, 8'd0, 0, 0, 1, 0);
      check_outs("pre idle", 0, 0, 0);
      // Stop clears the prescaler: a resume needs a full 4 cycles again
      step(1, 8'd3, 0, 0, 0, 0);
      step(0, 8'd0, 1, 0, 1, 0);
      step(0, 8'd0, 0, 0, 1, 0);
      step(0, 8'd0, 0, 0, 1, 0);
      step(0, 8'd0, 0, 0, 1, 0);
      check_outs("pre before stop", 3, 1, 0);
      step(0, 8'd0, 0, 1, 1, 0);
      step(0, 8'd0, 1, 0, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 8'd0, 0, 0, 1, 0);
         check_outs($sformatf("pre resume%0d", i), (i < 4) ? 3 : 2, 1, 0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
